sha256_resp_collector: RTL and testbench

//  On-chip response compactor for the SHA-256 test flow. Sits beside the SHA-256 core,

---
 rtl/sha256_resp_collector.sv | 122 ++++++++++++
 tb/tb_sha256_resp_collector.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sha256_resp_collector.sv
// Folds each SHA-256 core digest into a 32-bit MISR signature. After N_BLOCKS
// digests it compares against a golden value; a watchdog catches a silent core.
module sha256_resp_collector #(
  parameter int unsigned N_BLOCKS  = 16,
  parameter int unsigned TIMEOUT   = 128,
  parameter logic [31:0] MISR_POLY = 32'h04C11DB7,
  parameter logic [31:0] SIG_SEED  = 32'h00000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         digest_valid,
  input  logic [255:0] digest,
  input  logic [31:0]  expected_sig,
  input  logic         clear,
  output logic [31:0]  signature,
  output logic [15:0]  block_count,
  output logic         done,
  output logic         pass,
  output logic         timeout_err
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt, wait_cnt_next;
  logic          dv_q;
  logic          dv_rise;
  logic [31:0]   fold;
  logic [31:0]   sig_n;
  logic [15:0]   count_inc;
  logic [31:0]   signature_next;
  logic [15:0]   block_count_next;
  logic          done_next, pass_next, timeout_err_next;

  assign dv_rise = digest_valid & ~dv_q;

  always_comb begin
    fold = 32'h0;
    for (int i = 0; i < 8; i++) begin
      fold = fold ^ digest[i*32 +: 32];
    end
  end

  assign sig_n     = {signature[30:0], 1'b0} ^ (signature[31] ? MISR_POLY : 32'h0) ^ fold;
  assign count_inc = block_count + 16'd1;

  always_comb begin
    state_next       = state;
    wait_cnt_next    = wait_cnt;
    signature_next   = signature;
    block_count_next = block_count;
    done_next        = done;
    pass_next        = pass;
    timeout_err_next = timeout_err;
    if (clear) begin
      state_next       = IDLE;
      wait_cnt_next    = '0;
      signature_next   = SIG_SEED;
      block_count_next = 16'd0;
      done_next        = 1'b0;
      pass_next        = 1'b0;
      timeout_err_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next    = WAIT;
            wait_cnt_next = '0;
          end
        end
        WAIT: begin
          // A new init/next discards the running hash, so it beats a coincident digest.
          if (start) begin
            wait_cnt_next = '0;
          end else if (dv_rise) begin
            signature_next   = sig_n;
            block_count_next = count_inc;
            if (count_inc == 16'(N_BLOCKS)) begin
              state_next = DONE;
              done_next  = 1'b1;
              pass_next  = (sig_n == expected_sig);
            end else begin
              state_next = IDLE;
            end
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            state_next       = ERR;
            timeout_err_next = 1'b1;
          end else begin
            wait_cnt_next = wait_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      dv_q        <= 1'b0;
      signature   <= SIG_SEED;
      block_count <= 16'd0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      wait_cnt    <= wait_cnt_next;
      dv_q        <= digest_valid;
      signature   <= signature_next;
      block_count <= block_count_next;
      done        <= done_next;
      pass        <= pass_next;
      timeout_err <= timeout_err_next;
    end
  end

endmodule

// File: tb/tb_sha256_resp_collector.sv
// Directed bench: three collector instances with different parameters share one
// stimulus stream; each scenario checks the instance whose parameters it targets.
module tb_sha256_resp_collector;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         digest_valid;
  logic [255:0] digest;
  logic [31:0]  expected_sig;
  logic         clear;

  logic [31:0] sig_a, sig_b, sig_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;
  logic        done_a, done_b, done_c;
  logic        pass_a, pass_b, pass_c;
  logic        terr_a, terr_b, terr_c;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model_sig;
  logic [31:0] f;

  always #5 clk = ~clk;

  sha256_resp_collector #(.N_BLOCKS(2), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .digest_valid(digest_valid), .digest(digest),
    .expected_sig(expected_sig), .clear(clear), .signature(sig_a), .block_count(cnt_a),
    .done(done_a), .pass(pass_a), .timeout_err(terr_a));

  sha256_resp_collector #(.N_BLOCKS(1), .TIMEOUT(128)) dut_b (
    .clk(clk), .rst(rst), .start(start), .digest_valid(digest_valid), .digest(digest),
    .expected_sig(expected_sig), .clear(clear), .signature(sig_b), .block_count(cnt_b),
    .done(done_b), .pass(pass_b), .timeout_err(terr_b));

  sha256_resp_collector #(.N_BLOCKS(16), .TIMEOUT(128)) dut_c (
    .clk(clk), .rst(rst), .start(start), .digest_valid(digest_valid), .digest(digest),
    .expected_sig(expected_sig), .clear(clear), .signature(sig_c), .block_count(cnt_c),
    .done(done_c), .pass(pass_c), .timeout_err(terr_c));

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
    $display("check %-24s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // start pulse, nwait idle cycles, one-cycle digest_valid pulse, one settle cycle
  task automatic do_round(input int nwait);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(nwait);
    digest_valid = 1'b1;
    step(1);
    digest_valid = 1'b0;
    step(1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] fv);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ fv;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; digest_valid = 1'b0; digest = '0;
    expected_sig = 32'h0; clear = 1'b0;
    step(2);
    chk("reset_sig", sig_a, 32'h0);
    chk("reset_cnt", 32'(cnt_a), 32'd0);
    chk("reset_flags", {29'd0, done_a, pass_a, terr_a}, 32'd0);
    rst = 1'b0;
    step(1);

    // 1: single block, zero digest, expected 0
    start = 1'b1; step(1); start = 1'b0;
    step(4);
    digest_valid = 1'b1;
    #1;
    chk("t1_done_before_edge", 32'(done_b), 32'd0);
    step(1);
    digest_valid = 1'b0;
    chk("t1_done", 32'(done_b), 32'd1);
    chk("t1_pass", 32'(pass_b), 32'd1);
    chk("t1_sig", sig_b, 32'h0);
    chk("t1_cnt", 32'(cnt_b), 32'd1);
    do_clear();

    // 2: two blocks of digest word0=1, signature 1 then 3
    digest = 256'h1;
    do_round(2);
    chk("t2_sig1", sig_a, 32'h1);
    chk("t2_done1", 32'(done_a), 32'd0);
    expected_sig = 32'h3;
    do_round(2);
    chk("t2_sig2", sig_a, 32'h3);
    chk("t2_done2", 32'(done_a), 32'd1);
    chk("t2_pass2", 32'(pass_a), 32'd1);
    do_clear();
    expected_sig = 32'h4;
    do_round(2);
    do_round(3);
    chk("t2_sig_bad", sig_a, 32'h3);
    chk("t2_done_bad", 32'(done_a), 32'd1);
    chk("t2_pass_bad", 32'(pass_a), 32'd0);
    do_clear();
    chk("t2_clear_cnt", 32'(cnt_a), 32'd0);

    // 3: watchdog, TIMEOUT=8
    start = 1'b1; step(1); start = 1'b0;
    step(7);
    chk("t3_terr_early", 32'(terr_a), 32'd0);
    step(1);
    chk("t3_terr", 32'(terr_a), 32'd1);
    start = 1'b1; step(1); start = 1'b0;
    digest_valid = 1'b1; step(1); digest_valid = 1'b0; step(1);
    chk("t3_sig_hold", sig_a, 32'h0);
    chk("t3_cnt_hold", 32'(cnt_a), 32'd0);
    chk("t3_terr_hold", 32'(terr_a), 32'd1);
    chk("t3_done", 32'(done_a), 32'd0);
    do_clear();
    chk("t3_clear_terr", 32'(terr_a), 32'd0);

    // 4: no fold without start; one fold per rise; start restarts watchdog
    digest_valid = 1'b1; step(1); digest_valid = 1'b0; step(1);
    chk("t4_no_start", 32'(cnt_a), 32'd0);
    start = 1'b1; step(1); start = 1'b0;
    step(2);
    digest_valid = 1'b1; step(4); digest_valid = 1'b0; step(1);
    chk("t4_held_cnt", 32'(cnt_a), 32'd1);
    chk("t4_held_sig", sig_a, 32'h1);
    expected_sig = 32'h3;
    start = 1'b1; step(1); start = 1'b0;
    step(5);
    start = 1'b1; step(1); start = 1'b0;
    step(6);
    chk("t4_restart_terr", 32'(terr_a), 32'd0);
    digest_valid = 1'b1; step(1); digest_valid = 1'b0; step(1);
    chk("t4_restart_cnt", 32'(cnt_a), 32'd2);
    chk("t4_restart_pass", 32'(pass_a), 32'd1);
    do_clear();

    // 5: async reset mid-WAIT, then clear in DONE
    do_round(1); do_round(1); do_round(1);
    chk("t5_sig3", sig_c, 32'h7);
    chk("t5_cnt3", 32'(cnt_c), 32'd3);
    start = 1'b1; step(1); start = 1'b0;
    step(2);
    rst = 1'b1;
    #1;
    chk("t5_rst_sig", sig_c, 32'h0);
    chk("t5_rst_cnt", 32'(cnt_c), 32'd0);
    chk("t5_rst_done_b", 32'(done_b), 32'd0);
    step(1);
    rst = 1'b0;
    step(1);
    expected_sig = 32'h1;
    do_round(2);
    chk("t5_b_done", 32'(done_b), 32'd1);
    do_clear();
    chk("t5_clear_done", {30'd0, done_b, pass_b}, 32'd0);
    chk("t5_clear_cnt", 32'(cnt_b), 32'd0);
    chk("t5_clear_sig", sig_b, 32'h0);

    // 6: 16 random digests against a model MISR
    model_sig = 32'h0;
    for (int r = 0; r < 16; r++) begin
      f = 32'h0;
      for (int w = 0; w < 8; w++) begin
        digest[w*32 +: 32] = $urandom;
        f = f ^ digest[w*32 +: 32];
      end
      model_sig = misr(model_sig, f);
      if (r == 15) expected_sig = model_sig;
      do_round($urandom_range(1, 4));
      chk($sformatf("t6_sig_%0d", r), sig_c, model_sig);
      chk($sformatf("t6_cnt_%0d", r), 32'(cnt_c), 32'(r + 1));
    end
    chk("t6_done", 32'(done_c), 32'd1);
    chk("t6_pass", 32'(pass_c), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
